// File: rtl/lfsr_rr_sched.sv
// lfsr_rr_sched: one 20-bit maximal-length LFSR (x^20 + x^17 + 1) shared by
// NREQ requesters. A round-robin arbiter hands out bursts of len+1 words over
// a valid/ready stream. The LFSR advances only on accepted words.
module lfsr_rr_sched #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,      // active-high asynchronous reset
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  seed_load,
  input  logic [19:0]           seed,
  output logic [NREQ-1:0]       grant,
  output logic [19:0]           rnd_data,
  output logic                  rnd_valid,
  input  logic                  rnd_ready,
  output logic                  busy,
  output logic                  max_tick
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [19:0] LFSR_ONE = 20'h00001;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_next;
  logic [19:0]       lfsr_q, lfsr_next, lfsr_step;
  logic [PTR_W-1:0]  ptr_q, ptr_next;
  logic [LEN_W-1:0]  cnt_q, cnt_next;
  logic [NREQ-1:0]   grant_next;
  logic              max_tick_next;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;
  logic              hs;

  assign lfsr_step = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
  assign rnd_valid = (state == BURST);
  assign busy      = (state == BURST);
  assign rnd_data  = lfsr_q;
  assign hs        = rnd_valid & rnd_ready;

  // Round-robin search: first set req bit starting at the pointer, wrapping.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PTR_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and datapath decisions for the IDLE/BURST controller.
  always_comb begin
    state_next    = state;
    lfsr_next     = lfsr_q;
    ptr_next      = ptr_q;
    cnt_next      = cnt_q;
    grant_next    = grant;
    max_tick_next = 1'b0;
    case (state)
      IDLE: begin
        // A zero seed would lock the LFSR, so it is replaced by 1.
        if (seed_load) lfsr_next = (seed == 20'h0) ? LFSR_ONE : seed;
        if (win_found) begin
          state_next = BURST;
          grant_next = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          cnt_next   = req_len[win_idx*LEN_W +: LEN_W];
          ptr_next   = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + PTR_W'(1);
        end
      end
      BURST: begin
        if (hs) begin
          lfsr_next     = lfsr_step;
          max_tick_next = (lfsr_step == LFSR_ONE);
          if (cnt_q != '0) begin
            cnt_next = cnt_q - LEN_W'(1);
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst in progress.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      lfsr_q   <= LFSR_ONE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant    <= '0;
      max_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values sampled at the same edge, independent of statement order.
      state    <= state_next;
      lfsr_q   <= lfsr_next;
      ptr_q    <= ptr_next;
      cnt_q    <= cnt_next;
      grant    <= grant_next;
      max_tick <= max_tick_next;
    end
  end

endmodule

// File: doc/lfsr_rr_sched.md
Name: lfsr_rr_sched

Overview:
- Shares one 20-bit maximal-length LFSR between NREQ requesters.
- Each requester asks for a burst of pseudo-random words. A round-robin arbiter grants one requester at a time.
- The granted requester receives words over a valid/ready stream. The LFSR advances only on accepted words, so no value is skipped or duplicated.
- Sits between the random-number consumers (scramblers, test-pattern engines) and the LFSR datapath. It also handles seeding and end-of-period signalling.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LEN_W, 4, width of each requester's burst-length field; burst = len+1 words (1..2^LEN_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-high reset; asserted when 1.
- req  input  NREQ  per-requester burst request, level-sensitive.
- req_len  input  NREQ*LEN_W  packed lengths; slice i = req_len[i*LEN_W +: LEN_W].
- seed_load  input  1  load seed into LFSR (honoured only in IDLE).
- seed  input  20  seed value.
- grant  output  NREQ  one-hot owner of current burst; 0 when idle.
- rnd_data  output  20  current LFSR state.
- rnd_valid  output  1  word available to granted requester.
- rnd_ready  input  1  granted requester accepts word.
- busy  output  1  burst in progress.
- max_tick  output  1  one-cycle pulse on LFSR period completion.

Behaviour:
- Reset values (rst_n=1, asynchronous):
  - state=IDLE, grant=0, rnd_valid=0, busy=0, max_tick=0.
  - LFSR=20'h00001, round-robin pointer=0, burst counter=0.
- LFSR step: next = {q[18:0], q[19]^q[16]} (x^20+x^17+1, period 2^20-1).
  - rnd_data always equals q.
- Seeding:
  - In IDLE, seed_load=1 loads seed at the next edge.
  - seed==0 loads 20'h00001, which prevents lock-up.
  - seed_load outside IDLE is ignored.
  - If seed_load and an arbitration win occur in the same IDLE cycle, both take effect: the burst starts with the loaded seed as its first word.
- States:
  - IDLE: if any req bit is set, pick the first set bit searching from pointer upward with wrap.
    - At the next edge: grant=onehot(i), latch count=req_len slice i, pointer=(i+1) mod NREQ, state=BURST, busy=1, rnd_valid=1.
    - Latency: req high at edge N gives grant and rnd_valid at edge N+1.
  - BURST: rnd_valid=1, grant held.
    - Handshake = rnd_valid & rnd_ready. Each handshake steps the LFSR; count decrements if nonzero.
    - Handshake with count==0 (last word): next edge gives state=IDLE, grant=0, rnd_valid=0, busy=0.
    - Idle is at least one cycle between bursts, even with back-to-back requests.
- rnd_ready=0 stalls: rnd_data, grant and count are held stable.
- Deassertion of req mid-burst is ignored; the burst completes its full length.
- req bits for non-granted requesters are sampled only in IDLE.
- max_tick is registered. It is 1 for exactly one cycle after any handshake whose step produces next state 20'h00001; otherwise 0.
- Reset mid-burst aborts the burst immediately and returns all outputs and state to reset values.

Test Plan:
- Reset, then req=2'b01 with len0=3 and rnd_ready=1:
  - grant=01 one cycle later.
  - rnd_data sequence is 00001, 00002, 00004, 00008.
  - Then grant=0 and busy=0.
- Round-robin fairness: req=2'b11 held with len=0 for both:
  - grants alternate 01, 10, 01, 10 with one idle cycle between each.
- Stall with len0=1: rnd_ready low for 5 cycles on the first word:
  - rnd_data stays 00001 and grant stays 01 throughout.
  - After ready rises, exactly 2 words are delivered (00001, 00002).
- Seed and period wrap: seed_load with seed=20'h80000 in IDLE, then a burst with len=1:
  - words are 80000, 00001.
  - max_tick pulses once, on the cycle after the first handshake.
- Seed edge cases:
  - seed=0 loads 00001.
  - seed_load during BURST has no effect on the delivered sequence.
- Reset mid-burst: assert rst_n on word 2 of a 4-word burst:
  - grant=0, rnd_valid=0, busy=0 immediately.
  - After release, the first delivered word is 00001.
